imemory_stage: RTL and testbench
================================

IMEMORY_STAGE -- requirements
Module: imemory_stage

Interface
REQ-001 Parameter DEPTH, default 64: number of 32-bit words in the internal data memory (power of two).
REQ-002 Parameter LAT, default 2: BUSY cycles per memory access (1..15).
REQ-003 im_clk  input  1  stage clock; all state updates on the rising edge.
REQ-004 im_rst_n  input  1  reset; asynchronous, active-low.
REQ-005 alu_result_in  input  `WORD  EX result; this is the byte address for loads and stores.
REQ-006 store_data_in  input  `WORD  data to store.
REQ-007 pc_in  input  `WORD  PC of the instruction in this stage.
REQ-008 mem_read, mem_write  input  1 each  load request and store request.
REQ-009 mem_to_reg_in, reg_write_in  input  1 each  control flags passed through to write-back.
REQ-010 read_data  output  `WORD  registered load data for write-back.
REQ-011 alu_result_out, pc_out  output  `WORD each  registered copies of alu_result_in and pc_in.
REQ-012 mem_to_reg_out, reg_write_out  output  1 each  registered control flags for write-back.
REQ-013 stall  output  1  combinational; upstream holds all inputs stable while it is high.
REQ-014 misaligned  output  1  registered one-cycle error pulse.

Function
REQ-015 The FSM SHALL have two states: IDLE and BUSY, plus a 4-bit down-counter cnt.
REQ-016 An access is "req": (mem_read | mem_write) & (alu_result_in[1:0]==0).
- Word index = alu_result_in[log2(DEPTH)+1:2].
- Higher address bits are ignored, so addresses wrap.
REQ-017 stall SHALL be (state==BUSY) | (state==IDLE & req).
REQ-018 IDLE & req: next state is BUSY; cnt loads LAT-1.
- The output registers load a bubble: reg_write_out=0, mem_to_reg_out=0, read_data unchanged.
REQ-019 BUSY & cnt!=0: cnt decrements; the bubble is held on the outputs.
REQ-020 BUSY & cnt==0: the access completes and the next state is IDLE.
- A store writes store_data_in to memory at this edge.
- A load registers mem[index] into read_data.
- alu_result_out, pc_out, mem_to_reg_out and reg_write_out load the held inputs.
REQ-021 Total latency of an accepted access is LAT+1 edges from first presentation; stall is high for exactly LAT+1 cycles.
REQ-022 IDLE & no memory op: all output registers load their inputs at the next edge.
- read_data loads 0; stall stays 0; there is no added latency.
REQ-023 mem_read & mem_write both high: the request is treated as a store only, and read_data gets 0 at completion.
REQ-024 Misaligned access (op high, alu_result_in[1:0]!=0), IDLE only:
- No memory read or write and no stall.
- misaligned=1 for one cycle; reg_write_out=0, mem_to_reg_out=0.
- pc_out and alu_result_out load normally.
REQ-025 A store followed by a load to the same index SHALL return the stored value, because the store commits before the next request is accepted.
REQ-026 misaligned SHALL be 0 in every cycle not covered by REQ-024.
REQ-027 Memory contents are not reset; reads of never-written words are undefined.

Reset
REQ-028 While im_rst_n=0 the following SHALL be forced to 0: read_data, alu_result_out, pc_out, mem_to_reg_out, reg_write_out, misaligned and cnt; state SHALL be IDLE.
REQ-029 stall SHALL be 0 during reset regardless of inputs.
REQ-030 Reset asserted in BUSY SHALL abort the access: no memory write occurs and the outputs are 0.
REQ-031 After im_rst_n rises, the first edge SHALL behave as IDLE.

Verification
REQ-032 ALU op pass-through, LAT=2: mem_read=0, mem_write=0, alu_result_in=0x1234, reg_write_in=1 -> next edge alu_result_out=0x1234, reg_write_out=1; stall=0 throughout.
REQ-033 Store then load: store 0xDEADBEEF at addr 0x10, then load addr 0x10 with mem_to_reg_in=1 ->
- stall high for 3 cycles on each access;
- read_data=0xDEADBEEF, mem_to_reg_out=1;
- reg_write_out=0 during both stalls.
REQ-034 Wrap-around, DEPTH=64: store 0x55 at addr 0x104, then load addr 0x004 -> read_data=0x55.
REQ-035 Misaligned load at addr 0x13 -> misaligned=1 for one cycle, reg_write_out=0, stall=0, memory unchanged.
REQ-036 Reset during BUSY: store 0xAAAA to addr 0x20 over old value 0x1, with im_rst_n low in the second stall cycle -> all outputs 0; a subsequent load of 0x20 returns 0x1.
REQ-037 Simultaneous read+write of 0x7 to addr 0x8 -> memory word 2 becomes 0x7, read_data=0.

Source files
------------

// File: rtl/imemory_stage.sv
// rtl/imemory_stage.sv - memory pipeline stage: multi-cycle data memory access
// with stall, misalignment pulse and registered write-back outputs.
module imemory_stage #(
  parameter int DEPTH = 64,
  parameter int LAT   = 2
) (
  input  logic        im_clk,
  input  logic        im_rst_n,
  input  logic [31:0] alu_result_in,
  input  logic [31:0] store_data_in,
  input  logic [31:0] pc_in,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic        mem_to_reg_in,
  input  logic        reg_write_in,
  output logic [31:0] read_data,
  output logic [31:0] alu_result_out,
  output logic [31:0] pc_out,
  output logic        mem_to_reg_out,
  output logic        reg_write_out,
  output logic        stall,
  output logic        misaligned
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

  state_t          state, state_nxt;
  logic [3:0]      cnt, cnt_nxt;
  logic [31:0]     mem [DEPTH];
  logic [AW-1:0]   idx;
  logic            op, aligned, req, bad, done;

  // Upper address bits are dropped, so word addresses wrap modulo DEPTH.
  assign idx     = alu_result_in[AW+1:2];
  assign op      = mem_read | mem_write;
  assign aligned = (alu_result_in[1:0] == 2'b00);
  assign req     = op & aligned;
  assign bad     = op & ~aligned;
  assign done    = (state == BUSY) && (cnt == 4'd0);

  always_ff @(posedge im_clk or negedge im_rst_n) begin
    if (!im_rst_n) begin
      state <= IDLE;
      cnt   <= 4'd0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      IDLE: begin
        if (req) begin
          state_nxt = BUSY;
          cnt_nxt   = 4'(LAT - 1);
        end
      end
      BUSY: begin
        if (cnt == 4'd0) state_nxt = IDLE;
        else             cnt_nxt   = cnt - 4'd1;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    stall = 1'b0;
    if (im_rst_n) stall = (state == BUSY) || req;
  end

  always_ff @(posedge im_clk or negedge im_rst_n) begin
    if (!im_rst_n) begin
      read_data      <= 32'd0;
      alu_result_out <= 32'd0;
      pc_out         <= 32'd0;
      mem_to_reg_out <= 1'b0;
      reg_write_out  <= 1'b0;
      misaligned     <= 1'b0;
    end else begin
      misaligned <= 1'b0;
      if (state == IDLE) begin
        if (req) begin
          mem_to_reg_out <= 1'b0;
          reg_write_out  <= 1'b0;
        end else begin
          alu_result_out <= alu_result_in;
          pc_out         <= pc_in;
          read_data      <= 32'd0;
          misaligned     <= bad;
          mem_to_reg_out <= bad ? 1'b0 : mem_to_reg_in;
          reg_write_out  <= bad ? 1'b0 : reg_write_in;
        end
      end else if (done) begin
        alu_result_out <= alu_result_in;
        pc_out         <= pc_in;
        mem_to_reg_out <= mem_to_reg_in;
        reg_write_out  <= reg_write_in;
        // A combined read+write request behaves as a pure store.
        read_data      <= mem_write ? 32'd0 : mem[idx];
      end
    end
  end

  always_ff @(posedge im_clk) begin
    if (done && mem_write) mem[idx] <= store_data_in;
  end

endmodule

// File: tb/tb_imemory_stage.sv
// tb/tb_imemory_stage.sv - self-checking bench for imemory_stage (DEPTH=64, LAT=2).
module tb_imemory_stage;

  localparam int LAT = 2;

  logic        im_clk = 1'b0;
  logic        im_rst_n;
  logic [31:0] alu_result_in, store_data_in, pc_in;
  logic        mem_read, mem_write, mem_to_reg_in, reg_write_in;
  logic [31:0] read_data, alu_result_out, pc_out;
  logic        mem_to_reg_out, reg_write_out, stall, misaligned;

  imemory_stage #(.DEPTH(64), .LAT(LAT)) dut (
    .im_clk(im_clk), .im_rst_n(im_rst_n),
    .alu_result_in(alu_result_in), .store_data_in(store_data_in), .pc_in(pc_in),
    .mem_read(mem_read), .mem_write(mem_write),
    .mem_to_reg_in(mem_to_reg_in), .reg_write_in(reg_write_in),
    .read_data(read_data), .alu_result_out(alu_result_out), .pc_out(pc_out),
    .mem_to_reg_out(mem_to_reg_out), .reg_write_out(reg_write_out),
    .stall(stall), .misaligned(misaligned)
  );

  always #5 im_clk = ~im_clk;

  typedef struct {
    logic        rd, wr;
    logic [31:0] addr, wdata, pc;
    logic        m2r, rw;
    int          stall_n;
    logic        chk_rd;
    logic [31:0] rdata;
    logic        m2r_o, rw_o, mis;
  } vec_t;

  typedef struct {
    logic        chk_rd;
    logic [31:0] rdata, alu, pc;
    logic        m2r, rw, mis;
  } exp_t;

  exp_t sb[$];
  vec_t tbl[$];
  int   errors = 0;
  int   checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic rd, input logic wr, input logic [31:0] addr,
                              input logic [31:0] wdata, input logic [31:0] pc,
                              input logic m2r, input logic rw, input int stall_n,
                              input logic chk_rd, input logic [31:0] rdata,
                              input logic m2r_o, input logic rw_o, input logic mis);
    vec_t v;
    v.rd = rd; v.wr = wr; v.addr = addr; v.wdata = wdata; v.pc = pc;
    v.m2r = m2r; v.rw = rw; v.stall_n = stall_n; v.chk_rd = chk_rd;
    v.rdata = rdata; v.m2r_o = m2r_o; v.rw_o = rw_o; v.mis = mis;
    return v;
  endfunction

  task automatic check_all_zero(input string tag);
    check({tag, "_read_data"}, read_data, 32'd0);
    check({tag, "_alu_out"}, alu_result_out, 32'd0);
    check({tag, "_pc_out"}, pc_out, 32'd0);
    check({tag, "_m2r_out"}, {31'd0, mem_to_reg_out}, 32'd0);
    check({tag, "_rw_out"}, {31'd0, reg_write_out}, 32'd0);
    check({tag, "_misaligned"}, {31'd0, misaligned}, 32'd0);
    check({tag, "_stall"}, {31'd0, stall}, 32'd0);
  endtask

  // Entered just after a falling edge; returns just after the next falling edge.
  task automatic apply(input vec_t v, input int n);
    exp_t e;
    mem_read = v.rd; mem_write = v.wr; alu_result_in = v.addr;
    store_data_in = v.wdata; pc_in = v.pc; mem_to_reg_in = v.m2r; reg_write_in = v.rw;
    sb.push_back('{chk_rd: v.chk_rd, rdata: v.rdata, alu: v.addr, pc: v.pc,
                   m2r: v.m2r_o, rw: v.rw_o, mis: v.mis});
    #1;
    if (v.stall_n == 0) begin
      check($sformatf("v%0d_no_stall", n), {31'd0, stall}, 32'd0);
      @(posedge im_clk); #1;
    end
    for (int k = 0; k < v.stall_n; k++) begin
      check($sformatf("v%0d_stall_c%0d", n, k), {31'd0, stall}, 32'd1);
      if (k > 0) check($sformatf("v%0d_bubble_rw_c%0d", n, k), {31'd0, reg_write_out}, 32'd0);
      @(posedge im_clk); #1;
    end
    mem_read = 1'b0; mem_write = 1'b0;
    #1;
    check($sformatf("v%0d_stall_released", n), {31'd0, stall}, 32'd0);
    e = sb.pop_front();
    if (e.chk_rd) check($sformatf("v%0d_read_data", n), read_data, e.rdata);
    check($sformatf("v%0d_alu_out", n), alu_result_out, e.alu);
    check($sformatf("v%0d_pc_out", n), pc_out, e.pc);
    check($sformatf("v%0d_m2r_out", n), {31'd0, mem_to_reg_out}, {31'd0, e.m2r});
    check($sformatf("v%0d_rw_out", n), {31'd0, reg_write_out}, {31'd0, e.rw});
    check($sformatf("v%0d_misaligned", n), {31'd0, misaligned}, {31'd0, e.mis});
    @(negedge im_clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    // rd wr addr wdata pc m2r rw | stall chk_rd rdata m2r_o rw_o mis
    tbl.push_back(mk(0, 0, 32'h1234, 32'h0,        32'h100, 0, 1, 0,     1, 32'h0,        0, 1, 0));
    tbl.push_back(mk(0, 1, 32'h10,   32'hDEADBEEF, 32'h104, 0, 0, LAT+1, 0, 32'h0,        0, 0, 0));
    tbl.push_back(mk(1, 0, 32'h10,   32'h0,        32'h108, 1, 1, LAT+1, 1, 32'hDEADBEEF, 1, 1, 0));
    tbl.push_back(mk(0, 1, 32'h104,  32'h55,       32'h10c, 0, 0, LAT+1, 0, 32'h0,        0, 0, 0));
    tbl.push_back(mk(1, 0, 32'h4,    32'h0,        32'h110, 1, 1, LAT+1, 1, 32'h55,       1, 1, 0));
    tbl.push_back(mk(1, 0, 32'h13,   32'h0,        32'h114, 1, 1, 0,     0, 32'h0,        0, 0, 1));
    tbl.push_back(mk(0, 0, 32'h3,    32'h0,        32'h118, 1, 1, 0,     1, 32'h0,        1, 1, 0));
    tbl.push_back(mk(1, 0, 32'h10,   32'h0,        32'h11c, 1, 1, LAT+1, 1, 32'hDEADBEEF, 1, 1, 0));
    tbl.push_back(mk(1, 1, 32'h8,    32'h7,        32'h120, 0, 0, LAT+1, 1, 32'h0,        0, 0, 0));
    tbl.push_back(mk(1, 0, 32'h8,    32'h0,        32'h124, 1, 1, LAT+1, 1, 32'h7,        1, 1, 0));
    tbl.push_back(mk(0, 1, 32'h12,   32'h999,      32'h128, 0, 1, 0,     0, 32'h0,        0, 0, 1));
    tbl.push_back(mk(1, 0, 32'h10,   32'h0,        32'h12c, 1, 1, LAT+1, 1, 32'hDEADBEEF, 1, 1, 0));
    tbl.push_back(mk(0, 1, 32'h20,   32'h1,        32'h130, 0, 0, LAT+1, 0, 32'h0,        0, 0, 0));

    // Reset with an aligned load requested: stall must stay low, outputs zero.
    im_rst_n = 1'b0;
    mem_read = 1'b1; mem_write = 1'b0; alu_result_in = 32'h10; store_data_in = 32'h0;
    pc_in = 32'h0; mem_to_reg_in = 1'b1; reg_write_in = 1'b1;
    @(negedge im_clk); #1;
    check_all_zero("reset");
    mem_read = 1'b0;
    @(negedge im_clk);
    im_rst_n = 1'b1;
    @(negedge im_clk);

    for (int i = 0; i < tbl.size(); i++) apply(tbl[i], i);

    // Reset in the second stall cycle of a store aborts it.
    mem_write = 1'b1; mem_read = 1'b0; alu_result_in = 32'h20; store_data_in = 32'hAAAA;
    pc_in = 32'h200; mem_to_reg_in = 1'b0; reg_write_in = 1'b1;
    #1;
    check("abort_stall_c0", {31'd0, stall}, 32'd1);
    @(posedge im_clk); #1;
    check("abort_stall_c1", {31'd0, stall}, 32'd1);
    im_rst_n = 1'b0;
    #1;
    check_all_zero("abort");
    @(posedge im_clk); #1;
    check_all_zero("abort_held");
    mem_write = 1'b0;
    @(negedge im_clk);
    im_rst_n = 1'b1;
    @(negedge im_clk);
    apply(mk(1, 0, 32'h20, 32'h0, 32'h204, 1, 1, LAT+1, 1, 32'h1, 1, 1, 0), 100);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
